// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, output-buffer state encoding, default width.
// Used by the ALU control decoder and the execute stage.
// Pure declarations; no logic.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Occupancy of the 2-entry output buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU datapath: result, zero flag, unsupported-code flag.
// Latency 0 (purely combinational).
// No flow control; the enclosing stage decides when a result is captured.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      code,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  // Decode the operation; unknown codes yield a zero result flagged illegal
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (code)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry in-order output buffer.
// Latency 1 cycle from accept to out_* when the buffer is empty or the head pops.
// in_ready drops only when both entries are occupied; depends on registered state only.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal
);

  logic [XLEN-1:0] core_result;
  logic            core_zero;
  logic            core_illegal;

  buf_state_t state_q, state_d;

  logic [XLEN-1:0] res_mem  [2];
  logic            zero_mem [2];
  logic [TAGW-1:0] tag_mem  [2];
  logic            ill_mem  [2];
  logic            wr_ptr;
  logic            rd_ptr;

  logic push;
  logic pop;

  // Compute ahead of the buffer so entries are stored already resolved
  alu_core #(.XLEN(XLEN)) u_core (
    .code    (in_alu_ctrl),
    .a       (in_op_a),
    .b       (in_op_b),
    .result  (core_result),
    .zero    (core_zero),
    .illegal (core_illegal)
  );

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next-state: push+pop in ONE keeps the count unchanged
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Buffer storage and 1-bit wrapping pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_mem[i]  <= '0;
        zero_mem[i] <= 1'b0;
        tag_mem[i]  <= '0;
        ill_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        res_mem[wr_ptr]  <= core_result;
        zero_mem[wr_ptr] <= core_zero;
        tag_mem[wr_ptr]  <= in_tag;
        ill_mem[wr_ptr]  <= core_illegal;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign out_result  = res_mem[rd_ptr];
  assign out_zero    = zero_mem[rd_ptr];
  assign out_tag     = tag_mem[rd_ptr];
  assign out_illegal = ill_mem[rd_ptr];

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_ctrl;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_tag;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32), .TAGW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_ctrl (in_alu_ctrl),
    .in_op_a     (in_op_a),
    .in_op_b     (in_op_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: {illegal, zero, result}
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    r  = 32'h0;
    il = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
      default: il = 1'b1;
    endcase
    return {il, (r == 32'h0), r};
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    in_valid    = v;
    in_alu_ctrl = c;
    in_op_a     = a;
    in_op_b     = b;
    in_tag      = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    logic [33:0] m;

    vecs[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 32'h00000005, 32'h00000005, 5'd2,  32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd3,  32'h0000F000, 1'b0, 1'b0};
    vecs[3] = '{4'b0001, 32'h0000000F, 32'h000000F0, 5'd4,  32'h000000FF, 1'b0, 1'b0};
    vecs[4] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd5,  32'h00000001, 1'b0, 1'b0};
    vecs[5] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd6,  32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{4'b0011, 32'h00000005, 32'h00000003, 5'd31, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000000, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    tick();
    tick();
    chk("reset_out_valid", {63'h0, out_valid}, 64'h0);
    chk("reset_in_ready",  {63'h0, in_ready}, 64'h1);
    chk("reset_fields", {24'h0, out_result, out_zero, out_tag, out_illegal}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table vectors, streaming with out_ready high: each result one cycle after accept
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag);
      chk($sformatf("vec%0d_in_ready", i), {63'h0, in_ready}, 64'h1);
      tick();
      chk($sformatf("vec%0d_out", i),
          {24'h0, out_valid, out_result, out_zero, out_tag, out_illegal},
          {24'h0, 1'b1, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].tag, vecs[i].exp_ill});
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    tick();
    chk("drain_empty", {63'h0, out_valid}, 64'h0);

    // Back-pressure: three back-to-back offers with consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd10, 32'd1, 5'd1);
    tick();
    drive(1'b1, 4'b0010, 32'd20, 32'd2, 5'd2);
    chk("bp_ready_2nd", {63'h0, in_ready}, 64'h1);
    tick();
    drive(1'b1, 4'b0010, 32'd30, 32'd3, 5'd3);
    chk("bp_ready_3rd_low", {63'h0, in_ready}, 64'h0);
    chk("bp_head_held", {27'h0, out_valid, out_result, out_tag}, {27'h0, 1'b1, 32'd11, 5'd1});
    tick();
    chk("bp_stall_stable", {26'h0, in_ready, out_valid, out_result, out_tag}, {26'h0, 1'b0, 1'b1, 32'd11, 5'd1});
    out_ready = 1'b1;
    tick();
    // Head 1 popped; third op still pending and now ready (state ONE)
    chk("bp_second_head", {26'h0, in_ready, out_valid, out_result, out_tag}, {26'h0, 1'b1, 1'b1, 32'd22, 5'd2});
    tick();
    // Push+pop in ONE: tag 2 leaves, tag 3 becomes head, occupancy still ONE
    chk("pp_one_head_new", {26'h0, in_ready, out_valid, out_result, out_tag}, {26'h0, 1'b1, 1'b1, 32'd33, 5'd3});
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    tick();
    chk("pp_drained", {63'h0, out_valid}, 64'h0);

    // Explicit push+pop from ONE with a different op
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'h00000100, 32'h00000001, 5'd9);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 4'b0110, 32'd50, 32'd8, 5'd10);
    tick();
    chk("pp2_head", {25'h0, in_ready, out_valid, out_result, out_tag, out_illegal},
        {25'h0, 1'b1, 1'b1, 32'd42, 5'd10, 1'b0});
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    tick();

    // Reset mid-traffic: fill both entries then assert reset asynchronously
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'd1, 32'd1, 5'd11);
    tick();
    drive(1'b1, 4'b0010, 32'd2, 32'd2, 5'd12);
    tick();
    chk("rst_full_before", {62'h0, in_ready, out_valid}, {62'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async", {24'h0, in_ready, out_valid, out_result, out_zero, out_tag, out_illegal},
        {24'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 1'b0});
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_no_stale", {63'h0, out_valid}, 64'h0);

    // Streaming: 100 random ops at one per cycle, latency exactly 1
    for (int k = 0; k < 100; k++) begin
      rc = 4'($urandom_range(0, 15));
      if (k % 4 != 3) begin
        case ($urandom_range(0, 4))
          0: rc = 4'b0000;
          1: rc = 4'b0001;
          2: rc = 4'b0010;
          3: rc = 4'b0110;
          default: rc = 4'b0111;
        endcase
      end
      ra = $urandom;
      rb = (k % 8 == 0) ? ra : $urandom;
      drive(1'b1, rc, ra, rb, 5'(k));
      m = model(rc, ra, rb);
      tick();
      chk($sformatf("stream%0d", k),
          {24'h0, out_valid, out_result, out_zero, out_tag, out_illegal},
          {24'h0, 1'b1, m[31:0], m[32], 5'(k), m[33]});
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
    tick();
    chk("stream_drained", {63'h0, out_valid}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage sitting directly downstream of the ALU control decoder. It accepts the 4-bit ALU operation code, two operands and a destination tag over a valid/ready handshake, and computes the result and zero flag. It holds results in a 2-entry in-order output buffer, so a stalled consumer (EX/MEM side) never loses data and upstream is back-pressured cleanly.

## Interface
Parameters:
- XLEN, 32, operand/result width
- TAGW, 5, destination-register tag width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept this cycle
- in_alu_ctrl  in  4  operation code from the ALU control decoder
- in_op_a  in  XLEN  operand A
- in_op_b  in  XLEN  operand B
- in_tag  in  TAGW  destination tag, passed through unchanged
- out_valid  out  1  head buffer entry valid
- out_ready  in  1  consumer accepts head entry
- out_result  out  XLEN  head result
- out_zero  out  1  head result == 0 (branch compare)
- out_tag  out  TAGW  head tag
- out_illegal  out  1  head entry had an unsupported code

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT. Any other code produces result 0, zero 1, illegal 1.
- ADD/SUB wrap modulo 2^XLEN; carry/overflow are discarded. SLT is signed two's-complement: result = {XLEN-1 zeros, (a < b)}.
- Accept = in_valid && in_ready. On accept, the computed {result, zero, tag, illegal} is written into the buffer tail.
- Pop = out_valid && out_ready; it removes the head. Entries leave in strict acceptance order.
- Buffer states by occupancy:
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE, with the new entry becoming head next cycle.
  - FULL: pop → ONE. No push is possible because in_ready is low.
- in_ready = (state != FULL), driven combinationally from registered state only, with no path from out_ready. out_valid = (state != EMPTY).
- Inputs are ignored when in_ready is low. Output fields are held stable while out_valid && !out_ready.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle), provided the buffer was empty or the head popped at edge N.
- Throughput: 1 op/cycle while out_ready stays high.
- Reset (async assert; deassert synchronised externally): state EMPTY, out_valid 0, in_ready 1, out_result 0, out_zero 0, out_tag 0, out_illegal 0. The buffer contents are cleared. An in-flight handshake on the reset cycle is dropped.
- Buffer pointers are 1 bit and wrap 1→0. Occupancy is never allowed to exceed 2.
- No combinational path from in_* to out_*.

## Structure
- Shared package alu_pkg holds:
  - ALU code localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - Buffer state encoding EMPTY/ONE/FULL.
  - Default XLEN.
  The decoder and this stage both import these codes.
- One sub-module, alu_core: purely combinational; inputs code, a, b; outputs result, zero, illegal. This stage instantiates it once, at the input side, ahead of the buffer.

## Test plan
- Reset mid-traffic: fill both entries, then assert rst → out_valid 0 and in_ready 1 asynchronously; no stale entry appears after release.
- Arithmetic: ADD 0x7FFFFFFF+1 → 0x80000000, zero 0; SUB 5-5 → 0, zero 1; AND 0xF0F0&0xFF00 → 0xF000; OR 0x0F|0xF0 → 0xFF.
- SLT signedness: a=0xFFFFFFFF (-1), b=1 → result 1; a=1, b=0xFFFFFFFF → 0. Illegal code 0011 → result 0, zero 1, illegal 1, and the tag still passes through.
- Back-pressure: out_ready=0 while three ops are offered back-to-back → first two accepted, in_ready low on the third cycle. Raise out_ready → outputs emerge in order with tags 1, 2, then the third is accepted.
- Streaming: out_ready=1, 100 random ops → one result per cycle, latency exactly 1, all results matching the model.
- Simultaneous push+pop in ONE: head popped and new op accepted on the same edge → occupancy stays ONE, and the next head is the new op.
